exception_handler: RTL and testbench
====================================

Name: exception_handler

Overview:
- Consumer end of the pipelined 2-bit exception-code path.
- Samples the code arriving from the MEM-stage exception register and captures the faulting PC and cause.
- Stalls the front end, drives a flush pulse train, then presents the cause to the control/status unit with a valid/ack handshake.
- Sits between the MEM/WB boundary and the top-level control logic.

Parameters:
PC_W, 16, width of faulting-instruction PC
FLUSH_CYCLES, 3, cycles flush is held high per exception (legal range 1..15)
CNT_W, 8, width of exception counter (EXC_COUNT_EN only)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
exp_error  input  2  exception code: 00 none, 01 arithmetic overflow, 10 invalid address, 11 illegal instruction
exp_pc  input  PC_W  PC of the instruction carrying exp_error
exc_ack  input  1  consumer accepts the reported exception
stall  output  1  freeze fetch/decode while an exception is in progress
flush  output  1  squash in-flight pipeline stages
exc_valid  output  1  cause registers hold a reportable exception
exc_code  output  2  captured exception code
exc_pc  output  PC_W  captured faulting PC
dropped  output  1  sticky: an exception arrived while busy and was discarded
exc_count  output  CNT_W  saturating count of accepted exceptions

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, stall=0, flush=0, exc_valid=0, exc_code=00, exc_pc=0, dropped=0, exc_count=0, flush counter=0. Reset mid-operation aborts everything immediately; no report survives.
- All outputs are registered. No combinational path from input to output.
- States: IDLE, FLUSH, REPORT.
- IDLE:
  - exp_error != 00 at a clock edge: capture exc_code<=exp_error and exc_pc<=exp_pc.
  - Load flush counter with FLUSH_CYCLES-1; go to FLUSH.
  - stall and flush go high on the following cycle (1-cycle latency).
  - exp_error == 00: stay in IDLE.
- FLUSH:
  - stall=1, flush=1.
  - Counter decrements each cycle. When it is 0, go to REPORT.
  - flush is therefore high for exactly FLUSH_CYCLES consecutive cycles.
- REPORT:
  - stall=1, flush=0, exc_valid=1.
  - exc_code and exc_pc are stable while exc_valid=1.
  - exc_ack=1 with exp_error==00: go to IDLE. exc_valid and stall drop the next cycle.
  - exc_ack=1 with exp_error!=00 (back-to-back): recapture code/pc, reload the counter, go directly to FLUSH. exc_valid drops, stall stays high, dropped is not set.
- Busy drop:
  - exp_error!=00 while in FLUSH, or in REPORT without exc_ack, is discarded: dropped<=1.
  - The captured code/pc are not overwritten.
  - dropped clears on the edge where exc_ack is accepted in REPORT. If the same edge also sees a drop condition, set wins.
- exc_ack outside REPORT is ignored.
- exc_code and exc_pc hold their last values in IDLE until the next capture.
- Codes are opaque 2-bit values; no priority among them. Only 00 means "no exception".

Optional Feature:
- Macro: EXC_COUNT_EN.
- Defined: exc_count increments by 1 on every accepted capture (IDLE capture or back-to-back capture) and saturates at 2^CNT_W-1. A drop does not count.
- Undefined: no counter register; exc_count is tied to 0.

Test Plan:
- Reset, then exp_error=10, exp_pc=0x0040 for one cycle with FLUSH_CYCLES=3 -> next cycle stall=1, flush=1 for exactly 3 cycles, then exc_valid=1 with exc_code=10 and exc_pc=0x0040 held until ack.
- In REPORT, assert exc_ack for one cycle with exp_error=00 -> next cycle exc_valid=0, stall=0, state IDLE. exc_code stays 10.
- During FLUSH, drive exp_error=01, exp_pc=0x0080 -> dropped=1, exc_code/exc_pc unchanged. dropped returns to 0 after ack.
- In REPORT, exc_ack=1 and exp_error=11, exp_pc=0x00C0 on the same edge -> exc_valid=0 and stall=1 next cycle, flush runs 3 cycles, then report code 11 / pc 0x00C0. dropped stays 0.
- Pull reset low asynchronously mid-FLUSH -> all outputs 0 immediately, with no clock edge required. After release, exc_valid=0 until a new exception arrives.
- With EXC_COUNT_EN and CNT_W=2, accept 5 exceptions -> exc_count reads 1, 2, 3, 3, 3. Without the macro, exc_count stays 0.

Source files
------------

// File: rtl/exception_handler.sv
// -----------------------------------------------------------------------------
// exception_handler
//
// Consumer end of the pipelined 2-bit exception-code path. An exception code
// arriving from the MEM-stage exception register is captured together with the
// faulting PC. The block then stalls the front end, holds a flush pulse train
// for FLUSH_CYCLES cycles, and finally presents the captured cause to the
// control/status unit with a valid/ack handshake.
//
// Exception codes: 00 none, 01 arithmetic overflow, 10 invalid address,
// 11 illegal instruction. Codes are opaque; only 00 means "no exception".
//
// Parameters:
//   PC_W          width of the faulting-instruction PC
//   FLUSH_CYCLES  cycles flush is held high per exception (1..15)
//   CNT_W         width of the accepted-exception counter
//
// Optional feature (macro EXC_COUNT_EN):
//   defined   : exc_count counts accepted captures, saturating at 2^CNT_W-1
//   undefined : no counter register, exc_count tied to zero
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   exp_error  in   2-bit exception code from the MEM stage
//   exp_pc     in   PC of the instruction carrying exp_error
//   exc_ack    in   consumer accepts the reported exception
//   stall      out  freeze fetch/decode while an exception is in progress
//   flush      out  squash in-flight pipeline stages
//   exc_valid  out  cause registers hold a reportable exception
//   exc_code   out  captured exception code
//   exc_pc     out  captured faulting PC
//   dropped    out  sticky: an exception arrived while busy and was discarded
//   exc_count  out  saturating count of accepted exceptions
// -----------------------------------------------------------------------------
module exception_handler #(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       exp_error,
  input  logic [PC_W-1:0]  exp_pc,
  input  logic             exc_ack,
  output logic             stall,
  output logic             flush,
  output logic             exc_valid,
  output logic [1:0]       exc_code,
  output logic [PC_W-1:0]  exc_pc,
  output logic             dropped,
  output logic [CNT_W-1:0] exc_count
);

  // Flush counter is wide enough for the full legal FLUSH_CYCLES range.
  localparam int               FC_W    = 4;
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t            r_state;
  logic [FC_W-1:0]   r_flush_cnt;
  logic              r_stall;
  logic              r_flush;
  logic              r_exc_valid;
  logic [1:0]        r_exc_code;
  logic [PC_W-1:0]   r_exc_pc;
  logic              r_dropped;

  logic              w_exc_in;

  assign w_exc_in = (exp_error != 2'b00);

  // Main exception FSM: capture, flush sequencing, report handshake, drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= {FC_W{1'b0}};
      r_stall     <= 1'b0;
      r_flush     <= 1'b0;
      r_exc_valid <= 1'b0;
      r_exc_code  <= 2'b00;
      r_exc_pc    <= {PC_W{1'b0}};
      r_dropped   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_exc_in) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FC_LOAD;
            r_stall     <= 1'b1;
            r_flush     <= 1'b1;
            r_exc_code  <= exp_error;
            r_exc_pc    <= exp_pc;
          end else begin
            r_state     <= ST_IDLE;
          end
        end

        ST_FLUSH: begin
          // Anything arriving mid-flush is discarded; the capture is kept.
          if (w_exc_in) begin
            r_dropped <= 1'b1;
          end
          // Counter reaching zero ends the flush train after FLUSH_CYCLES cycles.
          if (r_flush_cnt == {FC_W{1'b0}}) begin
            r_state     <= ST_REPORT;
            r_flush     <= 1'b0;
            r_exc_valid <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt - {{(FC_W-1){1'b0}}, 1'b1};
          end
        end

        ST_REPORT: begin
          if (exc_ack) begin
            // An acknowledged report never counts as a drop, so the clear applies.
            r_dropped   <= 1'b0;
            r_exc_valid <= 1'b0;
            if (w_exc_in) begin
              // Back-to-back exception: recapture and flush again, stall held.
              r_state     <= ST_FLUSH;
              r_flush_cnt <= FC_LOAD;
              r_flush     <= 1'b1;
              r_exc_code  <= exp_error;
              r_exc_pc    <= exp_pc;
            end else begin
              r_state     <= ST_IDLE;
              r_stall     <= 1'b0;
            end
          end else if (w_exc_in) begin
            r_dropped <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_flush_cnt <= {FC_W{1'b0}};
          r_stall     <= 1'b0;
          r_flush     <= 1'b0;
          r_exc_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_COUNT_EN
  logic              w_capture;
  logic [CNT_W-1:0]  r_exc_count;

  // A capture is accepted from IDLE or as a back-to-back capture in REPORT.
  assign w_capture = w_exc_in &&
                     ((r_state == ST_IDLE) || ((r_state == ST_REPORT) && exc_ack));

  // Saturating counter of accepted exceptions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exc_count <= {CNT_W{1'b0}};
    end else if (w_capture && (r_exc_count != {CNT_W{1'b1}})) begin
      r_exc_count <= r_exc_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign exc_count = r_exc_count;
`else
  assign exc_count = {CNT_W{1'b0}};
`endif

  assign stall     = r_stall;
  assign flush     = r_flush;
  assign exc_valid = r_exc_valid;
  assign exc_code  = r_exc_code;
  assign exc_pc    = r_exc_pc;
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_exception_handler.sv
// -----------------------------------------------------------------------------
// tb_exception_handler
//
// Directed scenarios followed by randomized traffic. A behavioural model keeps
// the number of flush cycles still owed and whether a report is pending, and
// derives the expected outputs from those quantities every cycle.
// -----------------------------------------------------------------------------
module tb_exception_handler;

  localparam int PC_W         = 16;
  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       exp_error = 2'b00;
  logic [PC_W-1:0]  exp_pc = '0;
  logic             exc_ack = 1'b0;
  logic             stall;
  logic             flush;
  logic             exc_valid;
  logic [1:0]       exc_code;
  logic [PC_W-1:0]  exc_pc;
  logic             dropped;
  logic [CNT_W-1:0] exc_count;

  exception_handler #(
    .PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .exp_error(exp_error), .exp_pc(exp_pc),
    .exc_ack(exc_ack), .stall(stall), .flush(flush), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .dropped(dropped),
    .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int              m_flush_left;
  bit              m_reporting;
  logic [1:0]      m_code;
  logic [PC_W-1:0] m_pc;
  bit              m_dropped;
  int              m_count;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_reporting  = 0;
    m_code       = 2'b00;
    m_pc         = '0;
    m_dropped    = 0;
    m_count      = 0;
  endtask

  function automatic int exp_count();
`ifdef EXC_COUNT_EN
    return m_count;
`else
    return 0;
`endif
  endfunction

  task automatic model_accept(input logic [1:0] e, input logic [PC_W-1:0] p);
    m_code       = e;
    m_pc         = p;
    m_flush_left = FLUSH_CYCLES;
    if (m_count < (1 << CNT_W) - 1) m_count++;
  endtask

  // One clock edge of the model with the inputs that edge sampled.
  task automatic model_step(input logic [1:0] e, input logic [PC_W-1:0] p,
                            input logic a);
    if (m_reporting) begin
      if (a) begin
        m_dropped   = 0;
        m_reporting = 0;
        if (e != 2'b00) model_accept(e, p);
      end else if (e != 2'b00) begin
        m_dropped = 1;
      end
    end else if (m_flush_left > 0) begin
      if (e != 2'b00) m_dropped = 1;
      m_flush_left--;
      if (m_flush_left == 0) m_reporting = 1;
    end else if (e != 2'b00) begin
      model_accept(e, p);
    end
  endtask

  task automatic check_outputs();
    check_val("stall",     32'(stall),     32'(m_flush_left > 0 || m_reporting));
    check_val("flush",     32'(flush),     32'(m_flush_left > 0));
    check_val("exc_valid", 32'(exc_valid), 32'(m_reporting));
    check_val("exc_code",  32'(exc_code),  32'(m_code));
    check_val("exc_pc",    32'(exc_pc),    32'(m_pc));
    check_val("dropped",   32'(dropped),   32'(m_dropped));
    check_val("exc_count", 32'(exc_count), 32'(exp_count()));
  endtask

  // Check model on falling edge, drive inputs, advance model on rising edge.
  task automatic cyc(input logic [1:0] e, input logic [PC_W-1:0] p, input logic a);
    @(negedge clk);
    check_outputs();
    exp_error = e;
    exp_pc    = p;
    exc_ack   = a;
    @(posedge clk);
    model_step(e, p, a);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_valid", 32'(exc_valid), 32'd0);
    check_val("rst_pc",    32'(exc_pc), 32'd0);
    reset = 1'b1;

    // Basic capture, 3-cycle flush, report, ack
    cyc(2'b10, 16'h0040, 1'b0);
    #1 check_val("t1_flush_on", 32'({stall, flush}), 32'd3);
    cyc(2'b00, 16'h0000, 1'b0);
    cyc(2'b00, 16'h0000, 1'b0);
    #1 check_val("t1_flush_3rd", 32'(flush), 32'd1);
    cyc(2'b00, 16'h0000, 1'b0);
    #1 check_val("t1_flush_off", 32'(flush), 32'd0);
    check_val("t1_valid", 32'(exc_valid), 32'd1);
    check_val("t1_code",  32'(exc_code), 32'd2);
    check_val("t1_pc",    32'(exc_pc), 32'h0040);
    cyc(2'b00, 16'h0000, 1'b0);
    cyc(2'b00, 16'h0000, 1'b1);
    #1 check_val("t1_ack_valid", 32'({exc_valid, stall}), 32'd0);
    check_val("t1_code_hold", 32'(exc_code), 32'd2);

    // Drop during flush
    cyc(2'b11, 16'h0010, 1'b0);
    cyc(2'b01, 16'h0080, 1'b0);
    #1 check_val("t2_dropped", 32'(dropped), 32'd1);
    check_val("t2_code", 32'(exc_code), 32'd3);
    check_val("t2_pc",   32'(exc_pc), 32'h0010);
    cyc(2'b00, 16'h0000, 1'b0);
    cyc(2'b00, 16'h0000, 1'b0);
    cyc(2'b00, 16'h0000, 1'b1);
    #1 check_val("t2_drop_clr", 32'(dropped), 32'd0);

    // Back-to-back capture on the ack edge
    cyc(2'b10, 16'h0020, 1'b0);
    repeat (3) cyc(2'b00, 16'h0000, 1'b0);
    cyc(2'b11, 16'h00C0, 1'b1);
    #1 check_val("t3_b2b", 32'({exc_valid, stall, flush, dropped}), 32'b0110);
    check_val("t3_pc", 32'(exc_pc), 32'h00C0);
    repeat (3) cyc(2'b00, 16'h0000, 1'b0);
    #1 check_val("t3_report", 32'({exc_valid, exc_code}), 32'b111);
    cyc(2'b00, 16'h0000, 1'b1);

    // Asynchronous reset mid-flush
    cyc(2'b01, 16'h0055, 1'b0);
    cyc(2'b00, 16'h0000, 1'b0);
    #2 reset = 1'b0;
    #1 check_val("t4_async", 32'({stall, flush, exc_valid, dropped, exc_code}), 32'd0);
    check_val("t4_pc",  32'(exc_pc), 32'd0);
    check_val("t4_cnt", 32'(exc_count), 32'd0);
    model_reset();
    #4 reset = 1'b1;
    repeat (3) cyc(2'b00, 16'h0000, 1'b0);

    // Counter saturation: 1, 2, 3, 3, 3 with CNT_W=2
    for (int k = 1; k <= 5; k++) begin
      cyc(2'b01, 16'(k), 1'b0);
`ifdef EXC_COUNT_EN
      #1 check_val("t5_count", 32'(exc_count), (k < 3) ? 32'(k) : 32'd3);
`else
      #1 check_val("t5_count", 32'(exc_count), 32'd0);
`endif
      repeat (3) cyc(2'b00, 16'h0000, 1'b0);
      cyc(2'b00, 16'h0000, 1'b1);
    end

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [1:0]      e;
      logic [PC_W-1:0] p;
      logic            a;
      e = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      p = PC_W'($urandom);
      a = ($urandom_range(0, 2) == 0);
      cyc(e, p, a);
    end
    cyc(2'b00, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
